// File: rtl/jt51_timer_bank.sv
// Bank of NTIM independent up-counting timers with per-timer reload, power-of-two
// prescaler, one-shot/auto-reload mode, sticky overflow flags and a shared active-low IRQ.
module jt51_timer_bank #(
  parameter int NTIM  = 2,
  parameter int CNT_W = 10,
  parameter int SEL_W = 1
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                cen,
  input  logic                value_we,
  input  logic [SEL_W-1:0]    sel,
  input  logic [CNT_W-1:0]    value,
  input  logic                ctrl_we,
  input  logic [NTIM-1:0]     run_set,
  input  logic [NTIM-1:0]     run_clr,
  input  logic [NTIM-1:0]     irq_en,
  input  logic [NTIM-1:0]     flag_clr,
  input  logic [NTIM-1:0]     oneshot,
  input  logic [4*NTIM-1:0]   div,
  output logic [NTIM-1:0]     running,
  output logic [NTIM-1:0]     flags,
  output logic [NTIM-1:0]     overflow,
  output logic                irq_n
);

  logic [CNT_W-1:0] rl_q  [NTIM];
  logic [CNT_W-1:0] rl_d  [NTIM];
  logic [CNT_W-1:0] cnt_q [NTIM];
  logic [CNT_W-1:0] cnt_d [NTIM];
  logic [14:0]      pre_q [NTIM];
  logic [14:0]      pre_d [NTIM];
  logic [3:0]       div_q [NTIM];
  logic [3:0]       div_d [NTIM];
  logic [NTIM-1:0]  run_q, run_d;
  logic [NTIM-1:0]  flag_q, flag_d;
  logic [NTIM-1:0]  ien_q, ien_d;
  logic [NTIM-1:0]  osh_q, osh_d;
  logic [NTIM-1:0]  ovf_q, ovf_d;
  logic             irq_n_q, irq_n_d;

  // Terminal prescaler value for a tick every 2^d cen pulses.
  function automatic logic [14:0] tick_lim(input logic [3:0] d);
    logic [15:0] full;
    full = (16'd1 << d) - 16'd1;
    return full[14:0];
  endfunction

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    rl_d    = rl_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    div_d   = div_q;
    run_d   = run_q;
    flag_d  = flag_q;
    ien_d   = ien_q;
    osh_d   = osh_q;
    ovf_d   = '0;
    irq_n_d = ~|(flag_q & ien_q);

    if (ctrl_we) begin
      ien_d = irq_en;
      osh_d = oneshot;
    end

    for (int i = 0; i < NTIM; i++) begin
      // Out-of-range sel never matches any index, so such writes are dropped.
      if (value_we && sel == SEL_W'(i)) rl_d[i] = value;

      // Control first; the counting path below may then set the flag, so set beats clear.
      if (ctrl_we) begin
        div_d[i] = div[4*i +: 4];
        if (run_clr[i]) begin
          run_d[i] = 1'b0;
        end else if (run_set[i] && !run_q[i]) begin
          run_d[i] = 1'b1;
          cnt_d[i] = rl_q[i];
          pre_d[i] = '0;
        end
        if (flag_clr[i]) flag_d[i] = 1'b0;
      end

      if (run_q[i] && cen) begin
        if (pre_q[i] == tick_lim(div_q[i])) begin
          pre_d[i] = '0;
          if (&cnt_q[i]) begin
            cnt_d[i]  = rl_q[i];
            flag_d[i] = 1'b1;
            ovf_d[i]  = 1'b1;
            if (osh_q[i]) run_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end else begin
          pre_d[i] = pre_q[i] + 15'd1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-timer arrays are small register files and are reset explicitly.
      for (int i = 0; i < NTIM; i++) begin
        rl_q[i]  <= '0;
        cnt_q[i] <= '0;
        pre_q[i] <= '0;
        div_q[i] <= '0;
      end
      run_q   <= '0;
      flag_q  <= '0;
      ien_q   <= '0;
      osh_q   <= '0;
      ovf_q   <= '0;
      irq_n_q <= 1'b1;
    end else begin
      rl_q    <= rl_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      div_q   <= div_d;
      run_q   <= run_d;
      flag_q  <= flag_d;
      ien_q   <= ien_d;
      osh_q   <= osh_d;
      ovf_q   <= ovf_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign running  = run_q;
  assign flags    = flag_q;
  assign overflow = ovf_q;
  assign irq_n    = irq_n_q;

endmodule
